subr8s_serial: RTL

- Bit-serial, handshaked signed subtractor computing DIFF = A − B on WIDTH-bit two's-complement operands.
- Produces a full-precision (WIDTH+1)-bit result, so it never overflows.
- It is the inverse-operation companion to the 8-bit signed adders in the arithmetic library: it reconstructs operands from sums and serves as a golden/recovery path in fault-resilience experiments.
- Uses a single full-subtractor cell iterated over the bits, trading latency for area.

---
 rtl/subr8s_serial.sv | 87 ++++++++
 1 files changed

// File: rtl/subr8s_serial.sv
// rtl/subr8s_serial.sv - bit-serial signed subtractor, diff = a - b at WIDTH+1 bits
module subr8s_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   diff,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             ai, bi, di, borrow_nx, last;

  // Arithmetic right shift leaves the sign bit in position 0 for the extension step.
  assign ai        = sh_a[0];
  assign bi        = sh_b[0];
  assign di        = ai ^ bi ^ borrow;
  assign borrow_nx = (~ai & bi) | (~(ai ^ bi) & borrow);
  assign last      = (cnt == CW'(WIDTH));
  assign in_ready  = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= (state_nx == DONE);
      busy      <= (state_nx == BUSY);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a   <= '0;
      sh_b   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a   <= a;
            sh_b   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
          end
        end
        BUSY: begin
          diff[cnt] <= di;
          sh_a      <= {sh_a[WIDTH-1], sh_a[WIDTH-1:1]};
          sh_b      <= {sh_b[WIDTH-1], sh_b[WIDTH-1:1]};
          borrow    <= borrow_nx;
          if (!last) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
